// File: rtl/gc_pkg.sv
// Shared types and constants for the garbled-circuit gate sequencer.
package gc_pkg;

  localparam int GC_S = 20;
  localparam int GC_K = 128;

  localparam logic [3:0] GATE_XOR = 4'b0110;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  // One garbling job as handed to the engine, at the default widths.
  typedef struct packed {
    logic [GC_S-1:0] gid;
    logic [3:0]      gate_logic;
    logic [1:0]      flags;
    logic [GC_K-1:0] lbl0;
    logic [GC_K-1:0] lbl1;
  } gate_job_t;

endpackage

// File: rtl/gate_hazard_chk.sv
// Flags a gate whose non-input operand wire has not yet been written back.
module gate_hazard_chk #(
  parameter int S = 20
) (
  input  logic [S-1:0] in0,
  input  logic [S-1:0] in1,
  input  logic         in0F,
  input  logic         in1F,
  input  logic [S-1:0] input_size,
  input  logic [S-1:0] wb_count,
  output logic         stall
);

  logic [S-1:0] off0;
  logic [S-1:0] off1;

  // Gate outputs occupy label addresses input_size + gate index.
  assign off0  = in0 - input_size;
  assign off1  = in1 - input_size;
  assign stall = (!in0F && (off0 >= wb_count)) || (!in1F && (off1 >= wb_count));

endmodule

// File: rtl/gate_sequencer.sv
// Sequences gates from the netlist ROM into garbling jobs and writes results back.
// Optional GATE_SEQ_STATS_EN adds stall_cycles / free_gates counters.
module gate_sequencer
  import gc_pkg::*;
#(
  parameter int S = GC_S,
  parameter int K = GC_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] num_gates,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] gid,
  input  logic [S-1:0] input_size,
  input  logic         in0F,
  input  logic         in1F,
  input  logic [S-1:0] in0,
  input  logic [S-1:0] in1,
  input  logic [3:0]   g_logic,
  output logic [S-1:0] lbl_raddr0,
  output logic [S-1:0] lbl_raddr1,
  input  logic [K-1:0] lbl_rdata0,
  input  logic [K-1:0] lbl_rdata1,
  output logic         lbl_we,
  output logic [S-1:0] lbl_waddr,
  output logic [K-1:0] lbl_wdata,
  output logic         job_valid,
  input  logic         job_ready,
  output logic [S-1:0] job_gid,
  output logic [3:0]   job_logic,
  output logic [1:0]   job_flags,
  output logic [K-1:0] job_lbl0,
  output logic [K-1:0] job_lbl1,
  input  logic         res_valid,
  input  logic [K-1:0] res_label
`ifdef GATE_SEQ_STATS_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [S-1:0] free_gates
`endif
);

  seq_state_t   state;
  seq_state_t   state_nx;
  logic [S-1:0] ng_q;
  logic [S-1:0] issue_cnt;
  logic [S-1:0] wb_count;
  logic         hazard;
  logic         fetch_go;
  logic         issue_fire;
  logic         wb_fire;
  logic         run_start;

  gate_hazard_chk #(.S(S)) u_hazard (
    .in0        (in0),
    .in1        (in1),
    .in0F       (in0F),
    .in1F       (in1F),
    .input_size (input_size),
    .wb_count   (wb_count),
    .stall      (hazard)
  );

  assign run_start  = (state == IDLE) && start;
  assign fetch_go   = (state == FETCH) && !hazard;
  assign issue_fire = (state == ISSUE) && job_ready;
  // A result with nothing outstanding, or arriving while idle, is dropped.
  assign wb_fire    = res_valid && (state != IDLE) && (wb_count != issue_cnt);

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    gid        = '0;
    lbl_raddr0 = '0;
    lbl_raddr1 = '0;
    job_valid  = 1'b0;
    lbl_we     = wb_fire;
    lbl_waddr  = '0;
    lbl_wdata  = '0;
    if (wb_fire) begin
      lbl_waddr = input_size + wb_count;
      lbl_wdata = res_label;
    end
    case (state)
      IDLE: begin
        if (start) state_nx = (num_gates == '0) ? DONE : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        gid  = issue_cnt;
        if (!hazard) begin
          lbl_raddr0 = in0;
          lbl_raddr1 = in1;
          state_nx   = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        job_valid = 1'b1;
        if (job_ready) state_nx = ((issue_cnt + S'(1)) == ng_q) ? DRAIN : FETCH;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wb_count == ng_q) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ng_q      <= '0;
      issue_cnt <= '0;
      wb_count  <= '0;
      job_gid   <= '0;
      job_logic <= '0;
      job_flags <= '0;
      job_lbl0  <= '0;
      job_lbl1  <= '0;
    end else begin
      state <= state_nx;
      if (run_start) begin
        ng_q      <= num_gates;
        issue_cnt <= '0;
        wb_count  <= '0;
      end else begin
        if (issue_fire) issue_cnt <= issue_cnt + S'(1);
        if (wb_fire)    wb_count  <= wb_count + S'(1);
      end
      if (fetch_go) begin
        job_gid   <= issue_cnt;
        job_logic <= g_logic;
        job_flags <= {in1F, in0F};
      end
      if (state == LOAD) begin
        job_lbl0 <= lbl_rdata0;
        job_lbl1 <= lbl_rdata1;
      end
    end
  end

`ifdef GATE_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      free_gates   <= '0;
    end else if (run_start) begin
      stall_cycles <= '0;
      free_gates   <= '0;
    end else begin
      if ((state == FETCH) && hazard && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (issue_fire && (job_logic == GATE_XOR) && (free_gates != '1))
        free_gates <= free_gates + S'(1);
    end
  end
`endif

endmodule
